// File: rtl/ram_pkg.sv
// Shared sizes and types for the FIFO controller sitting in front of the 16x8 dual-port RAM.
package ram_pkg;

   localparam int DATA_W = 8;
   localparam int ADDR_W = 4;
   localparam int DEPTH  = 16;

   typedef logic [DATA_W-1:0] data_t;
   typedef logic [ADDR_W-1:0] addr_t;
   typedef logic [4:0]        cnt_t;

   // DEPTH is a power of two, so natural overflow of the address gives the wrap.
   function automatic addr_t next_ptr(input addr_t p);
      return p + addr_t'(1);
   endfunction

endpackage

// File: rtl/ram_fifo_skid.sv
// Two-entry in-order buffer that catches RAM read data and presents the FIFO head.
module ram_fifo_skid
   import ram_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic [1:0]        cnt,
   output logic [DATA_W-1:0] head
);

   data_t slot0;
   data_t slot1;

   assign head = slot0;

   // slot0 is always the head; a pop shifts slot1 forward.
   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt   <= 2'd0;
         slot0 <= '0;
         slot1 <= '0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (cnt == 2'd0) slot0 <= push_data;
               else             slot1 <= push_data;
               cnt <= cnt + 2'd1;
            end
            2'b01: begin
               slot0 <= slot1;
               cnt   <= cnt - 2'd1;
            end
            2'b11: begin
               if (cnt == 2'd1) begin
                  slot0 <= push_data;
               end else begin
                  slot0 <= slot1;
                  slot1 <= push_data;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller: turns a push stream into RAM writes and RAM reads into an in-order pop
// stream, with a two-word prefetch so the pop side can sustain one word per clock.
module ram_fifo_ctrl
   import ram_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [4:0]        level,
   output logic              wr_enb,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              rd_enb,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] rd_data
);

   addr_t      wr_ptr;
   addr_t      rd_ptr;
   cnt_t       ram_cnt;
   logic       rd_pend;
   logic [1:0] skid_cnt;
   logic       pop;
   logic [2:0] skid_claim;

   assign in_ready = rst & (ram_cnt != cnt_t'(DEPTH));
   assign wr_enb   = in_valid & in_ready;
   assign wr_addr  = wr_ptr;
   assign wr_data  = in_data;

   assign out_valid = (skid_cnt != 2'd0);
   assign pop       = out_valid & out_ready;

   // Skid slots that will be occupied once the in-flight read lands and this cycle's pop leaves.
   assign skid_claim = {1'b0, skid_cnt} + {2'b00, rd_pend} - {2'b00, pop};
   assign rd_enb     = rst & (ram_cnt != '0) & (skid_claim < 3'd2);
   assign rd_addr    = rd_ptr;

   assign level = ram_cnt + cnt_t'(rd_pend) + cnt_t'(skid_cnt);

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         ram_cnt <= '0;
         rd_pend <= 1'b0;
      end else begin
         if (wr_enb) wr_ptr <= next_ptr(wr_ptr);
         if (rd_enb) rd_ptr <= next_ptr(rd_ptr);
         rd_pend <= rd_enb;
         ram_cnt <= ram_cnt + cnt_t'(wr_enb) - cnt_t'(rd_enb);
      end
   end

   // rd_pend marks the cycle in which the RAM output carries the word requested one edge earlier.
   ram_fifo_skid u_skid (
      .clk       (clk),
      .rst       (rst),
      .push      (rd_pend),
      .push_data (rd_data),
      .pop       (pop),
      .cnt       (skid_cnt),
      .head      (out_data)
   );

endmodule
